// File: rtl/gray_code_counter_if.sv
// Counter control and count-value bundle between the stimulus side (master)
// and the Gray counter (slave).
interface gray_code_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             wrap;
    logic             tc;

    modport master (
        output en, up, load, load_val,
        input  gray_out, bin_out, wrap, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output gray_out, bin_out, wrap, tc
    );
endinterface

// File: rtl/gray_code_counter.sv
// Up/down counter keeping binary and Gray values in separate registers so the
// Gray output is glitch-free and moves one bit per step.
module gray_code_counter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    gray_code_counter_if.slave bus
);
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic [WIDTH-1:0] load_gray;
    logic             at_end;

    // Terminal count depends on the live direction input, not a registered copy.
    always_comb begin
        next_bin = bin_q;
        at_end   = 1'b0;
        if (bus.up) begin
            next_bin = bin_q + 1'b1;
            at_end   = &bin_q;
        end else begin
            next_bin = bin_q - 1'b1;
            at_end   = ~|bin_q;
        end
    end

    assign next_gray = next_bin ^ (next_bin >> 1);
    assign load_gray = bus.load_val ^ (bus.load_val >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else if (bus.load) begin
            bin_q  <= bus.load_val;
            gray_q <= load_gray;
            wrap_q <= 1'b0;
        end else if (bus.en) begin
            bin_q  <= next_bin;
            gray_q <= next_gray;
            wrap_q <= at_end;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.wrap     = wrap_q;
    assign bus.tc       = at_end;
endmodule

// File: doc/gray_code_counter.md
Name: gray_code_counter

Overview:
- Parameterised up/down counter that produces registered Gray-code and binary count values.
- Sits directly upstream of the 4-bit Gray-to-binary converter stage.
- gray_out drives that converter's Gray input; bin_out is the golden reference for checking the converter output.
- Gray state is held in its own register, so gray_out is glitch-free and changes exactly one bit per count step.

Parameters:
- WIDTH, 4, counter width in bits for gray_out, bin_out and load_val. Legal range is 2 to 16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; advances the count by one step when high.
- up  input  1  direction: 1 counts up, 0 counts down; sampled only when en=1.
- load  input  1  synchronous load of load_val; has priority over en.
- load_val  input  WIDTH  binary value to load.
- gray_out  output  WIDTH  registered Gray code of the current count.
- bin_out  output  WIDTH  registered binary value of the current count.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap-around step.
- tc  output  1  combinational terminal count: high when bin_out is all-ones and up=1, or when bin_out is zero and up=0.

Behaviour:
- Register update priority on each rising clk edge: rst, then load, then en, then hold.
- rst=1: gray_out=0, bin_out=0, wrap=0. tc then reflects up (tc=1 when up=0).
- load=1 (and rst=0):
  - bin_out <= load_val.
  - gray_out <= load_val ^ (load_val >> 1).
  - wrap <= 0.
  - en and up are ignored in that cycle.
- en=1, up=1: next binary value nb = bin_out + 1 modulo 2^WIDTH.
- en=1, up=0: nb = bin_out - 1 modulo 2^WIDTH.
- On a count step: bin_out <= nb and gray_out <= nb ^ (nb >> 1), both in the same edge.
- Latency: both outputs update one cycle after en/load is sampled. bin_out and gray_out always describe the same count.
- wrap <= 1 in either of these cases, otherwise wrap <= 0 on every edge:
  - en=1, up=1 and bin_out is all-ones (count goes to 0).
  - en=1, up=0 and bin_out is 0 (count goes to all-ones).
- en=0 and load=0: all registers hold, and wrap <= 0.
- Invariant: gray_out == bin_out ^ (bin_out >> 1) in every cycle after the first reset.
- Invariant: across any count step, exactly one bit of gray_out changes (Hamming distance 1). This includes the wrap steps.
- Direction reversal on consecutive cycles is legal; each step still changes exactly one Gray bit.
- rst asserted mid-count overrides load and en in the same cycle. There is no residual wrap pulse after reset.
- Out-of-range bits do not exist: load_val is exactly WIDTH bits, and all arithmetic is modulo 2^WIDTH with no saturation.
- Before the first reset, outputs are undefined; the bench must apply rst for at least 1 cycle.

Test Plan (all scenarios use WIDTH=4):
- Reset, then en=1, up=1 for 17 cycles:
  - bin_out steps 0,1,...,15,0,1.
  - gray_out steps 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000,0001.
  - wrap is high only in the cycle after bin_out goes 15->0.
  - tc is high while bin_out=15.
- Reset, then en=1, up=0 for 2 cycles: bin_out=15, gray_out=1000, wrap=1, then bin_out=14, gray_out=1001, wrap=0.
- load=1, load_val=1010 with en=1, up=1 in the same cycle: next cycle bin_out=1010, gray_out=1111, wrap=0. The count does not advance.
- Count to bin_out=5, then en=0 for 3 cycles: outputs hold at 0101/0111 and wrap=0. Then up=0, en=1: bin_out=4, gray_out=0110.
- rst=1 asserted together with load=1 and en=1 at bin_out=9: next cycle all outputs are 0.
- Random en/up/load for 2000 cycles with a scoreboard:
  - gray_out == bin_out ^ (bin_out >> 1) every cycle.
  - Exactly one gray_out bit changes per count step.
  - Feeding gray_out into the downstream Gray-to-binary converter reproduces bin_out.
